// File: rtl/zx_vram_pkg.sv
//------------------------------------------------------------------------------
// Module  : zx_vram_pkg
// Purpose : Shared VRAM geometry and the enumerations used by the arbiter and
//           its read-return tag pipeline.
// Contents: VRAM_AW / VRAM_DW  - video RAM address / data widths (8 KB x 8)
//           src_t              - owner of an in-flight RAM read
//           arb_state_t        - CPU transaction state of the arbiter
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package zx_vram_pkg;

  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 8;

  // Who a RAM read slot belongs to; SRC_NONE marks an idle or write slot.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_CPU  = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_WR = 2'd1,
    CPU_RD = 2'd2
  } arb_state_t;

endpackage : zx_vram_pkg

`default_nettype wire

// File: rtl/vram_rd_tag_pipe.sv
//------------------------------------------------------------------------------
// Module  : vram_rd_tag_pipe
// Purpose : Tracks the owner of each RAM read for the two edges it takes to
//           come back, then captures ram_rdata into the owner's data register
//           with a one-cycle valid pulse.
// Ports   : clk_i        - VRAM clock
//           reset_i      - synchronous active-low reset
//           issue_i      - owner of the read granted this cycle (or SRC_NONE)
//           ram_rdata_i  - RAM read data
//           cpu_ret_o    - a CPU read is captured at the coming edge
//           vid_valid_o  - vid_data_o updated this cycle
//           vid_data_o   - last byte returned to video
//           cpu_valid_o  - cpu_rdata_o updated this cycle
//           cpu_rdata_o  - last byte returned to the CPU
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vram_rd_tag_pipe
  import zx_vram_pkg::*;
#(
  parameter int DW = VRAM_DW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  src_t          issue_i,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          cpu_ret_o,
  output logic          vid_valid_o,
  output logic [DW-1:0] vid_data_o,
  output logic          cpu_valid_o,
  output logic [DW-1:0] cpu_rdata_o
);

  // tag0 follows the address register, tag1 lines up with ram_rdata.
  src_t          tag0_q;
  src_t          tag1_q;
  logic          vid_valid_q;
  logic [DW-1:0] vid_data_q;
  logic          cpu_valid_q;
  logic [DW-1:0] cpu_rdata_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      tag0_q      <= SRC_NONE;
      tag1_q      <= SRC_NONE;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      tag0_q      <= issue_i;
      tag1_q      <= tag0_q;
      vid_valid_q <= (tag1_q == SRC_VID);
      cpu_valid_q <= (tag1_q == SRC_CPU);
      if (tag1_q == SRC_VID) begin
        vid_data_q <= ram_rdata_i;
      end
      if (tag1_q == SRC_CPU) begin
        cpu_rdata_q <= ram_rdata_i;
      end
    end
  end

  assign cpu_ret_o   = (tag1_q == SRC_CPU);
  assign vid_valid_o = vid_valid_q;
  assign vid_data_o  = vid_data_q;
  assign cpu_valid_o = cpu_valid_q;
  assign cpu_rdata_o = cpu_rdata_q;

endmodule : vram_rd_tag_pipe

`default_nettype wire

// File: rtl/vram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : vram_arbiter
// Purpose : Shares the single-port video RAM between the ULA fetch path and
//           the CPU. Video has fixed priority; after MAX_VID_RUN consecutive
//           video grants with the CPU waiting, the next slot goes to the CPU.
//           One RAM access per clock, read data steered back in grant order.
// Ports   : clk_i, reset_i           - VRAM clock, sync active-low reset
//           vid_req_i/vid_addr_i     - video fetch request (held until grant)
//           vid_gnt_o                - combinational video grant
//           vid_valid_o/vid_data_o   - returned video byte (pulse)
//           cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i - CPU request (held to ack)
//           cpu_ack_o/cpu_rdata_o    - CPU completion pulse / read data
//           ram_addr_o/ram_we_o/ram_wdata_o - registered RAM controls
//           ram_rdata_i              - RAM data, valid one cycle after address
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vram_arbiter
  import zx_vram_pkg::*;
#(
  parameter int AW          = VRAM_AW,
  parameter int DW          = VRAM_DW,
  parameter int MAX_VID_RUN = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic          vid_gnt_o,
  output logic          vid_valid_o,
  output logic [DW-1:0] vid_data_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam int              RUN_W   = (MAX_VID_RUN < 1) ? 1 : $clog2(MAX_VID_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);

  arb_state_t       state_q, state_d;
  logic [RUN_W-1:0] vid_run_q, vid_run_d;
  logic             wr_ack_q, wr_ack_d;
  logic [AW-1:0]    ram_addr_q;
  logic             ram_we_q;
  logic [DW-1:0]    ram_wdata_q;

  logic cpu_ok;
  logic cpu_win;
  logic vid_win;
  logic cpu_ret;
  logic cpu_rvalid;
  src_t issue;

  assign cpu_ack_o = wr_ack_q | cpu_rvalid;

  // The ack cycle still belongs to the finishing transaction: cpu_req is
  // still high there, so a grant now would repeat the access. A held
  // request becomes a new transaction only from the cycle after the ack.
  always_comb begin
    cpu_ok  = reset_i && cpu_req_i && (state_q == IDLE) && !cpu_ack_o;
    cpu_win = cpu_ok && (!vid_req_i || (vid_run_q == RUN_MAX));
    vid_win = reset_i && vid_req_i && !cpu_win;
  end

  assign vid_gnt_o = vid_win;

  // Counts video grants that overtook a waiting CPU.
  always_comb begin
    vid_run_d = vid_run_q;
    if (!cpu_req_i || cpu_win) begin
      vid_run_d = '0;
    end else if (vid_win && cpu_ok && (vid_run_q != RUN_MAX)) begin
      vid_run_d = vid_run_q + RUN_W'(1);
    end
  end

  // Writes need no read return slot.
  always_comb begin
    issue = SRC_NONE;
    if (cpu_win && !cpu_we_i) begin
      issue = SRC_CPU;
    end else if (vid_win) begin
      issue = SRC_VID;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_win) begin
          state_d = cpu_we_i ? CPU_WR : CPU_RD;
        end
      end
      CPU_WR: state_d = IDLE;
      CPU_RD: begin
        if (cpu_ret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. The write strobe is on the RAM while in CPU_WR, so the
  // ack is registered for the following cycle.
  always_comb begin
    wr_ack_d = (state_q == CPU_WR);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      vid_run_q   <= '0;
      wr_ack_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      vid_run_q <= vid_run_d;
      wr_ack_q  <= wr_ack_d;
      ram_we_q  <= 1'b0;
      if (cpu_win) begin
        ram_addr_q  <= cpu_addr_i;
        ram_we_q    <= cpu_we_i;
        ram_wdata_q <= cpu_wdata_i;
      end else if (vid_win) begin
        ram_addr_q <= vid_addr_i;
      end
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;

  vram_rd_tag_pipe #(
    .DW (DW)
  ) u_tag_pipe (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .issue_i     (issue),
    .ram_rdata_i (ram_rdata_i),
    .cpu_ret_o   (cpu_ret),
    .vid_valid_o (vid_valid_o),
    .vid_data_o  (vid_data_o),
    .cpu_valid_o (cpu_rvalid),
    .cpu_rdata_o (cpu_rdata_o)
  );

endmodule : vram_arbiter

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_vram_arbiter
// Purpose : Self-checking bench for vram_arbiter with a synchronous RAM model,
//           a golden memory image and return-data scoreboards.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vram_arbiter;

  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int MAXR = 4;
  // Sample-index distance from the grant sample to the response sample.
  localparam int L_VID = 3;
  localparam int L_WR  = 2;
  localparam int L_RD  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_VID_RUN(MAXR)) dut (
    .clk_i(clk), .reset_i(reset),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_gnt_o(vid_gnt),
    .vid_valid_o(vid_valid), .vid_data_o(vid_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
  endfunction

  // Synchronous-read RAM; unwritten locations hold pat(addr).
  bit [7:0] mem  [8192];
  bit       memv [8192];
  always @(posedge clk) begin
    ram_rdata <= memv[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    if (ram_we) begin
      mem[ram_addr]  <= ram_wdata;
      memv[ram_addr] <= 1'b1;
    end
  end

  function automatic logic [7:0] mem_rd(input logic [12:0] a);
    return memv[a] ? mem[a] : pat(a);
  endfunction

  logic [7:0] gold [int];
  function automatic logic [7:0] gold_rd(input logic [12:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : pat(a);
  endfunction

  typedef struct { logic [7:0] data; int cyc; } vexp_t;
  typedef struct { logic we; logic [7:0] data; int cyc; } cexp_t;
  typedef struct { logic we; logic [12:0] addr; logic [7:0] wdata; } ctx_t;
  typedef struct { logic [12:0] addr; int cyc; } welog_t;
  typedef struct {
    logic vreq; logic creq; logic cwe;
    logic [12:0] vaddr; logic [12:0] caddr; logic [7:0] cwd;
    logic exp_gnt; logic exp_we; logic [12:0] exp_addr;
  } vec_t;

  vexp_t  vq  [$];
  cexp_t  cq  [$];
  ctx_t   ctq [$];
  welog_t wel [$];
  vec_t   vecs [6];

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          vid_left = 0;
  logic [12:0] vid_next = '0;
  logic        cpu_presented = 1'b0;
  int          ack_cnt = 0;
  int          last_cpu_lat = -1;
  logic        s_vid_gnt, s_ram_we;
  logic [12:0] s_ram_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor();
    vexp_t ve;
    cexp_t ce;
    s_vid_gnt  = vid_gnt;
    s_ram_we   = ram_we;
    s_ram_addr = ram_addr;
    if (vid_gnt) begin
      vq.push_back('{data: gold_rd(vid_addr), cyc: cyc});
      vid_left--;
      vid_next++;
    end
    if (vid_valid) begin
      if (vq.size() == 0) check("vid_valid_spurious", 32'(vid_valid), 32'd0);
      else begin
        ve = vq.pop_front();
        check("vid_data", 32'(vid_data), 32'(ve.data));
        check("vid_latency", 32'(cyc - ve.cyc), 32'(L_VID));
      end
    end
    if (cpu_ack) begin
      ack_cnt++;
      if (cq.size() == 0) check("cpu_ack_spurious", 32'(cpu_ack), 32'd0);
      else begin
        ce = cq.pop_front();
        last_cpu_lat = cyc - ce.cyc;
        if (!ce.we) check("cpu_rdata", 32'(cpu_rdata), 32'(ce.data));
        if (ctq.size() > 0) ctq.delete(0);
        cpu_presented = 1'b0;
      end
    end
    if (ram_we) wel.push_back('{addr: ram_addr, cyc: cyc});
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive this cycle's requests from the driver state, then advance a clock.
  task automatic step();
    if (ctq.size() > 0 && !cpu_presented) begin
      cq.push_back('{we: ctq[0].we, data: ctq[0].we ? 8'h00 : gold_rd(ctq[0].addr), cyc: cyc});
      if (ctq[0].we) gold[int'(ctq[0].addr)] = ctq[0].wdata;
      cpu_presented = 1'b1;
    end
    vid_req  = (vid_left > 0);
    vid_addr = vid_next;
    cpu_req  = (ctq.size() > 0);
    if (ctq.size() > 0) begin
      cpu_we = ctq[0].we; cpu_addr = ctq[0].addr; cpu_wdata = ctq[0].wdata;
    end else begin
      cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    end
    cycle();
  endtask

  task automatic run_until_idle(input int maxc);
    int k = 0;
    while ((vid_left > 0 || ctq.size() > 0 || vq.size() > 0 || cq.size() > 0) && k < maxc) begin
      step();
      k++;
    end
    check("drain_pending", 32'(vq.size() + cq.size() + ctq.size() + vid_left), 32'd0);
    step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vid_left = 0;
    ctq.delete(); vq.delete(); cq.delete();
    cpu_presented = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vid_gnt"},   32'(vid_gnt),   32'd0);
    check({tag, "_vid_valid"}, 32'(vid_valid), 32'd0);
    check({tag, "_vid_data"},  32'(vid_data),  32'd0);
    check({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_ram_we"},    32'(ram_we),    32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] gp;
    reset = 1'b0; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // vreq creq cwe vaddr caddr cwd | gnt we addr (first grant from reset)
    vecs[0] = '{1'b0, 1'b0, 1'b0, 13'h0000, 13'h0000, 8'h00, 1'b0, 1'b0, 13'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 13'h0123, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h0123};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 13'h0000, 13'h0456, 8'h3C, 1'b0, 1'b1, 13'h0456};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 13'h0000, 13'h0789, 8'h00, 1'b0, 1'b0, 13'h0789};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 13'h0222, 13'h1000, 8'h77, 1'b1, 1'b0, 13'h0222};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 13'h0333, 13'h0456, 8'h00, 1'b1, 1'b0, 13'h0333};

    do_reset();
    check_zero("reset");

    // Continuous video stream, 8 addresses, no CPU.
    vid_left = 8; vid_next = 13'h0000;
    for (int i = 0; i < 8; i++) begin
      step();
      check("stream_gnt", 32'(s_vid_gnt), 32'd1);
    end
    run_until_idle(20);

    // Single-cycle arbitration vectors, each from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      vid_left = vecs[i].vreq ? 1 : 0;
      vid_next = vecs[i].vaddr;
      if (vecs[i].creq) ctq.push_back('{we: vecs[i].cwe, addr: vecs[i].caddr, wdata: vecs[i].cwd});
      step();
      check("vec_gnt", 32'(s_vid_gnt), 32'(vecs[i].exp_gnt));
      step();
      check("vec_ram_we", 32'(s_ram_we), 32'(vecs[i].exp_we));
      check("vec_ram_addr", 32'(s_ram_addr), 32'(vecs[i].exp_addr));
      run_until_idle(20);
    end

    // CPU write 0x1800 <= 0xA5 with video idle.
    do_reset();
    ack_cnt = 0;
    ctq.push_back('{we: 1'b1, addr: 13'h1800, wdata: 8'hA5});
    step();
    step();
    check("wr_ram_we", 32'(s_ram_we), 32'd1);
    check("wr_ram_addr", 32'(s_ram_addr), 32'h1800);
    run_until_idle(20);
    check("wr_ack_count", 32'(ack_cnt), 32'd1);
    check("wr_ack_latency", 32'(last_cpu_lat), 32'(L_WR));
    check("ram_model_1800", 32'(mem_rd(13'h1800)), 32'hA5);

    // CPU read 0x1800.
    ack_cnt = 0;
    ctq.push_back('{we: 1'b0, addr: 13'h1800, wdata: 8'h00});
    run_until_idle(20);
    check("rd_ack_count", 32'(ack_cnt), 32'd1);
    check("rd_ack_latency", 32'(last_cpu_lat), 32'(L_RD));

    // CPU read under a continuous video stream: 4 video grants, CPU slot, resume.
    do_reset();
    ack_cnt = 0;
    vid_left = 14; vid_next = 13'h0100;
    step();
    step();
    ctq.push_back('{we: 1'b0, addr: 13'h1800, wdata: 8'h00});
    gp = 6'b101111;
    for (int j = 0; j < 6; j++) begin
      step();
      check("starve_gnt", 32'(s_vid_gnt), 32'(gp[j]));
    end
    run_until_idle(40);
    check("starve_ack_count", 32'(ack_cnt), 32'd1);
    check("starve_ack_latency", 32'(last_cpu_lat), 32'(MAXR + L_RD));

    // Three back-to-back writes with cpu_req held high throughout.
    do_reset();
    ack_cnt = 0;
    wel.delete();
    ctq.push_back('{we: 1'b1, addr: 13'h0000, wdata: 8'h11});
    ctq.push_back('{we: 1'b1, addr: 13'h0001, wdata: 8'h22});
    ctq.push_back('{we: 1'b1, addr: 13'h0002, wdata: 8'h33});
    run_until_idle(40);
    check("b2b_ack_count", 32'(ack_cnt), 32'd3);
    check("b2b_we_count", 32'(wel.size()), 32'd3);
    if (wel.size() == 3) begin
      for (int i = 0; i < 3; i++) check("b2b_we_addr", 32'(wel[i].addr), 32'(i));
      for (int i = 1; i < 3; i++) check("b2b_we_spacing", 32'(wel[i].cyc - wel[i-1].cyc), 32'd3);
    end
    vid_left = 3; vid_next = 13'h0000;
    run_until_idle(20);

    // Reset pulsed at E+1 of a CPU read: the read must be dropped.
    do_reset();
    ack_cnt = 0;
    ctq.push_back('{we: 1'b0, addr: 13'h1800, wdata: 8'h00});
    step();
    reset = 1'b0;
    ctq.delete(); cq.delete(); vq.delete();
    cpu_presented = 1'b0;
    step();
    reset = 1'b1;
    check_zero("midreset");
    for (int i = 0; i < 5; i++) step();
    check("midreset_no_ack", 32'(ack_cnt), 32'd0);
    ctq.push_back('{we: 1'b1, addr: 13'h0010, wdata: 8'h5C});
    run_until_idle(20);
    check("midreset_idle_wr_latency", 32'(last_cpu_lat), 32'(L_WR));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_vram_arbiter

`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 8 KB video RAM between two requesters:
  - the ULA video fetch path, which needs bitmap and attribute bytes;
  - the CPU, which reads and writes screen memory through a req/ack handshake.
- Grants at most one RAM access per clock and pipelines the read data back to whichever requester issued it.
- Gives video fixed priority, with a bounded-starvation guarantee for the CPU.
- Sits between the video subsystem / CPU bus glue and the VRAM block, in the VRAM clock domain.

Parameters:
- AW, 13, VRAM address width.
- DW, 8, VRAM data width.
- MAX_VID_RUN, 4, maximum consecutive video grants while the CPU is waiting; the next slot is forced to the CPU.

Ports:
- clk  in  1  VRAM clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- vid_req  in  1  video fetch request; held with vid_addr until vid_gnt.
- vid_addr  in  AW  video fetch address.
- vid_gnt  out  1  combinational; video request accepted this cycle.
- vid_valid  out  1  one-cycle pulse; vid_data valid.
- vid_data  out  DW  fetched byte.
- cpu_req  in  1  CPU access request; held with cpu_we/cpu_addr/cpu_wdata until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle pulse; transaction complete.
- cpu_rdata  out  DW  read data, valid with cpu_ack on reads.
- ram_addr  out  AW  registered RAM address.
- ram_we  out  1  registered RAM write strobe.
- ram_wdata  out  DW  registered RAM write data.
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_addr is presented.

Behaviour:
- Reset (reset==0 at posedge):
  - all outputs = 0; FSM = IDLE; vid_run = 0; read-tag pipeline cleared.
  - Any in-flight read is discarded: no vid_valid or cpu_ack is generated for it.
- Arbitration, decided combinationally each cycle from inputs and state:
  - cpu_ok = cpu_req && FSM==IDLE.
  - CPU wins if cpu_ok && (!vid_req || vid_run==MAX_VID_RUN); otherwise video wins if vid_req.
  - vid_gnt = vid_req && video wins.
- Grant edge E:
  - ram_addr/ram_we/ram_wdata are loaded from the winner.
  - With no winner: ram_we=0 and ram_addr holds its value.
  - ram_we is never 1 for a video grant.
- vid_run:
  - increments, saturating at MAX_VID_RUN, on each video grant made while cpu_ok was 1;
  - clears on a CPU grant or when cpu_req==0.
- FSM states IDLE, CPU_WR, CPU_RD:
  - IDLE -> CPU_WR on a CPU write grant; -> CPU_RD on a CPU read grant.
  - CPU_WR: cpu_ack=1 for the cycle after E+1; -> IDLE.
  - CPU_RD: waits on the tag pipeline; at E+2 cpu_rdata <= ram_rdata and cpu_ack=1 for one cycle; -> IDLE.
- Read-return tag pipeline (2 stages, source in {NONE, VID, CPU}):
  - a video grant at E gives vid_data <= ram_rdata and a vid_valid pulse at E+2.
  - Reads are returned in grant order; video accesses may be granted every cycle (fully pipelined).
- CPU request rules:
  - The CPU is not re-granted while FSM != IDLE.
  - If cpu_req is still high in the cycle after cpu_ack, it is a new transaction (eligible from that cycle).
- Worst case: CPU grant within MAX_VID_RUN+1 cycles of cpu_req under a continuous video stream.
- Simultaneous requests: vid_gnt=0 when the CPU wins; video holds its request and is granted next cycle.
- No combinational path from ram_rdata to any output.

Decomposition:
- Package zx_vram_pkg:
  - localparams VRAM_AW=13 and VRAM_DW=8;
  - typedef enum src_t {SRC_NONE, SRC_VID, SRC_CPU};
  - typedef enum arb_state_t {IDLE, CPU_WR, CPU_RD}.
- One natural sub-module, vram_rd_tag_pipe: a 2-stage src_t shift register plus data capture/steering to vid_data/cpu_rdata.
- Arbitration and the FSM stay in vram_arbiter.

Test Plan:
- Continuous vid_req, addresses 0x0000..0x0007, cpu_req=0:
  - vid_gnt=1 every cycle; 8 vid_valid pulses, each 2 edges after its grant, data equal to the RAM model contents in order.
- Idle video; CPU write 0x1800 <= 0xA5:
  - ram_we=1 and ram_addr=0x1800 at E+1; cpu_ack pulse once; model reads 0xA5.
- Idle video; CPU read 0x1800:
  - cpu_ack at E+2 with cpu_rdata=0xA5; exactly one ack.
- Continuous video stream, cpu_req raised (read) with MAX_VID_RUN=4:
  - exactly 4 video grants, then a CPU grant with vid_gnt=0 that cycle, then video resumes;
  - vid_data stays correctly ordered around the CPU slot.
- CPU read granted, reset pulsed low at E+1:
  - no cpu_ack or vid_valid afterwards; all outputs 0; FSM IDLE.
- cpu_req held high across 3 back-to-back writes to 0x0000/0x0001/0x0002:
  - 3 acks, no duplicate ram_we to the same address, and no grant while FSM != IDLE.
